// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared widths and FSM encoding for the stalling data memory
package dmem_pkg;

    // Default geometry: 256 entries of 8 bits
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 8;

    // Wait counter is sized for the largest supported LATENCY (15)
    localparam int CNT_W = 4;

    // FSM encoding, 2 bits
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - storage array with sync write, comb read and sync clear-all
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_clear,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    // Clear wins over a coincident write so an abandoned store never lands
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_memory_stall.sv
// rtl/data_memory_stall.sv - multi-cycle data memory that stalls the pipeline via BUSYWAIT
module data_memory_stall
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int LATENCY = 5
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] WRITEDATA,
    output logic [DATA_W-1:0] READDATA,
    output logic              BUSYWAIT
);

    // Counter preload: LATENCY edges are spent in ACCESS, the last one performs the access
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_write;
    logic [DATA_W-1:0] r_readdata;

    logic              w_req_valid;
    logic              w_fire;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;

    // Exactly one of READ/WRITE is a legal request; both high is ignored
    assign w_req_valid = READ ^ WRITE;
    assign w_fire      = (r_state == ST_ACCESS) && (r_cnt == '0);
    assign w_we        = w_fire && r_is_write;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .i_clk   (CLOCK),
        .i_clear (RESET),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    // FSM, wait counter and request latches; reset abandons any access in flight
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_readdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_valid) begin
                        r_addr     <= ADDRESS;
                        r_wdata    <= WRITEDATA;
                        r_is_write <= WRITE;
                        r_cnt      <= LAT_M1;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (!r_is_write) begin
                            r_readdata <= w_rdata;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall is raised combinationally in IDLE so the request cycle itself is held
    always_comb begin
        BUSYWAIT = 1'b0;
        case (r_state)
            ST_IDLE:   BUSYWAIT = w_req_valid;
            ST_ACCESS: BUSYWAIT = 1'b1;
            default:   BUSYWAIT = 1'b0;
        endcase
    end

    assign READDATA = r_readdata;

endmodule

// File: tb/tb_data_memory_stall.sv
// tb/tb_data_memory_stall.sv - self-checking bench for data_memory_stall
module tb_data_memory_stall;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rd_a = 1'b0, wr_a = 1'b0;
    logic [7:0] addr_a = 8'h00, wd_a = 8'h00, rdata_a;
    logic       busy_a;
    logic       rst_b = 1'b1, rd_b = 1'b0, wr_b = 1'b0;
    logic [7:0] addr_b = 8'h00, wd_b = 8'h00, rdata_b;
    logic       busy_b;

    int errors = 0;
    int checks = 0;

    // Reference: per-instance memory image and last loaded value
    logic [7:0] mem_m [2][256];
    logic [7:0] last_rd [2];

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       corrupt;
        logic [7:0] exp_rd;
    } vec_t;

    always #5 clk = ~clk;

    data_memory_stall #(.ADDR_W(8), .DATA_W(8), .LATENCY(5)) u_a (
        .CLOCK(clk), .RESET(rst_a), .READ(rd_a), .WRITE(wr_a),
        .ADDRESS(addr_a), .WRITEDATA(wd_a), .READDATA(rdata_a), .BUSYWAIT(busy_a)
    );

    data_memory_stall #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) u_b (
        .CLOCK(clk), .RESET(rst_b), .READ(rd_b), .WRITE(wr_b),
        .ADDRESS(addr_b), .WRITEDATA(wd_b), .READDATA(rdata_b), .BUSYWAIT(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
        if (w == 0) begin
            rd_a = rd; wr_a = wr; addr_a = a; wd_a = d;
        end else begin
            rd_b = rd; wr_b = wr; addr_b = a; wd_b = d;
        end
    endtask

    function automatic logic busy_of(input int w);
        return (w == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [7:0] rdata_of(input int w);
        return (w == 0) ? rdata_a : rdata_b;
    endfunction

    // Cycle-level contract: busy for LATENCY+1 cycles from the request, then one
    // cycle low with the result. The request is held until DONE ends, like a stalled CPU.
    task automatic do_access(input int w, input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, input logic corrupt, input logic [7:0] exp_rd,
                             input string nm);
        int lat;
        lat = (w == 0) ? 5 : 1;
        drive(w, rd, wr, a, d);
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            chk($sformatf("%s busy c%0d", nm, c), 32'(busy_of(w)), 32'd1);
            @(posedge clk); #1;
            if (c == 0 && corrupt) drive(w, rd, wr, 8'h00, 8'hFF);
        end
        @(negedge clk);
        chk($sformatf("%s done busy", nm), 32'(busy_of(w)), 32'd0);
        chk($sformatf("%s rdata", nm), 32'(rdata_of(w)), 32'(exp_rd));
        @(posedge clk); #1;
        drive(w, 1'b0, 1'b0, a, d);
        if (wr && !rd) mem_m[w][a] = d;
        last_rd[w] = exp_rd;
    endtask

    task automatic rand_ops(input int w, input int n);
        logic       is_rd, corrupt;
        logic [7:0] a, d, e;
        for (int i = 0; i < n; i++) begin
            is_rd   = 1'($urandom_range(0, 1));
            corrupt = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            d = 8'($urandom);
            e = is_rd ? mem_m[w][a] : last_rd[w];
            do_access(w, is_rd, !is_rd, a, d, corrupt, e, $sformatf("rnd%0d_%0d", w, i));
        end
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{rd:1'b1, wr:1'b0, addr:8'h10, wdata:8'h00, corrupt:1'b0, exp_rd:8'h00};
        vecs[1] = '{rd:1'b0, wr:1'b1, addr:8'h3C, wdata:8'hA5, corrupt:1'b1, exp_rd:8'h00};
        vecs[2] = '{rd:1'b1, wr:1'b0, addr:8'h3C, wdata:8'h00, corrupt:1'b0, exp_rd:8'hA5};
        vecs[3] = '{rd:1'b1, wr:1'b0, addr:8'h00, wdata:8'h00, corrupt:1'b0, exp_rd:8'h00};
        vecs[4] = '{rd:1'b0, wr:1'b1, addr:8'h80, wdata:8'h5A, corrupt:1'b0, exp_rd:8'h00};
        vecs[5] = '{rd:1'b1, wr:1'b0, addr:8'h80, wdata:8'h00, corrupt:1'b0, exp_rd:8'h5A};
        vecs[6] = '{rd:1'b1, wr:1'b0, addr:8'h3C, wdata:8'h00, corrupt:1'b1, exp_rd:8'hA5};

        for (int w = 0; w < 2; w++) begin
            last_rd[w] = 8'h00;
            for (int i = 0; i < 256; i++) mem_m[w][i] = 8'h00;
        end

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset busy_a", 32'(busy_a), 32'd0);
        chk("reset rdata_a", 32'(rdata_a), 32'd0);
        chk("reset busy_b", 32'(busy_b), 32'd0);
        chk("reset rdata_b", 32'(rdata_b), 32'd0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;

        // Directed table on the LATENCY=5 instance
        for (int i = 0; i < 7; i++) begin
            do_access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].corrupt, vecs[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Illegal READ+WRITE in IDLE: no stall, no state change, memory untouched
        drive(0, 1'b1, 1'b1, 8'h3C, 8'h11);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("illegal busy c%0d", c), 32'(busy_a), 32'd0);
            chk($sformatf("illegal rdata c%0d", c), 32'(rdata_a), 32'hA5);
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        do_access(0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 8'hA5, "after_illegal");

        // Reset in cycle 3 of a store: abandoned, array and READDATA cleared
        drive(0, 1'b0, 1'b1, 8'h20, 8'h77);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid busy c%0d", c), 32'(busy_a), 32'd1);
            @(posedge clk); #1;
        end
        rst_a = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk("rstmid busy c3", 32'(busy_a), 32'd1);
        @(posedge clk); #1;
        rst_a = 1'b0;
        @(negedge clk);
        chk("post reset busy", 32'(busy_a), 32'd0);
        chk("post reset rdata", 32'(rdata_a), 32'd0);
        for (int i = 0; i < 256; i++) mem_m[0][i] = 8'h00;
        last_rd[0] = 8'h00;
        @(posedge clk); #1;
        do_access(0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, "rd20_after_rst");
        do_access(0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b0, 8'h00, "rd3c_after_rst");

        // LATENCY=1 instance: top address, two-cycle stalls
        do_access(1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, "b_wr_ff");
        do_access(1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hFF, "b_rd_ff");

        // Randomised traffic against the reference model
        rand_ops(0, 30);
        rand_ops(1, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
